inst_fetch: RTL and testbench

// - Front-end fetch unit; drives the IF/ID pipeline register: inst, inst address, interrupt flag.
// - Owns the PC and masters the instruction-ROM request/response bus.
// - Keeps up to FIFO_DEPTH requests in flight.
// - Redirects on jump_flag_i and obeys the pipeline hold bus.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_pkg;

  localparam int HOLD_W = 3;
  localparam int INT_W  = 8;

  localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

  localparam logic [INT_W-1:0] INT_NONE  = 8'h00;
  localparam logic [31:0]      INST_NOP  = 32'h0000_0013;
  localparam logic [31:0]      ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH_ST_FETCH = 1'b0,
    FETCH_ST_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rptr_r;
  logic [AW-1:0] wptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Accept a push into a full FIFO only when the head leaves in the same cycle.
  always_comb begin
    full      = (count_r == (AW+1)'(DEPTH));
    empty     = (count_r == {(AW+1){1'b0}});
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    head      = mem_r[rptr_r];
    count     = count_r;
  end

  // Pointer and occupancy state; flush wins over any push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rptr_r  <= {AW{1'b0}};
      wptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && !rst) begin
      mem_r[wptr_r] <= din;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: owns the PC, issues ROM requests, buffers responses and feeds IF/ID.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOLD_W-1:0] hold_flag_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  output logic              req_o,
  output logic [31:0]       addr_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [CW-1:0] outstanding_r, outstanding_s;
  logic [CW-1:0] kill_r, kill_s;
  logic          req_pend_r;
  logic          req_s, issue_ok_s, grant_s, resp_s, drop_s, iq_pop_s;
  logic [CW:0]   fill_s;

  logic [31:0]   aq_head_s;
  logic [CW-1:0] aq_count_s, iq_count_s;
  logic          aq_full_s, aq_empty_s, iq_full_s, iq_empty_s;
  fetch_entry_t  iq_head_s;
  fetch_entry_t  iq_din_s;
  logic          unused_s;

  assign unused_s = ^{aq_full_s, aq_count_s, iq_full_s, jump_addr_i[1:0]};
  assign iq_din_s = '{addr: aq_head_s, inst: rdata_i};

  // A raised request stays up until granted; only a jump, reset or flush drops it.
  always_comb begin
    fill_s     = {1'b0, outstanding_r} + {1'b0, iq_count_s};
    issue_ok_s = (hold_flag_i < HOLD_PC) && (fill_s < (CW+1)'(FIFO_DEPTH));
    if (rst || jump_flag_i || (state_r != FETCH_ST_FETCH)) begin
      req_s = 1'b0;
    end else begin
      req_s = req_pend_r || issue_ok_s;
    end
    grant_s  = req_s && gnt_i;
    drop_s   = rvalid_i && (kill_r != {CW{1'b0}});
    resp_s   = rvalid_i && (kill_r == {CW{1'b0}}) && !aq_empty_s;
    iq_pop_s = !iq_empty_s && (hold_flag_i < HOLD_IF) && !jump_flag_i;
  end

  // Next PC / in-flight bookkeeping; a jump turns every live request into a kill.
  always_comb begin
    outstanding_s = outstanding_r + CW'(grant_s) - CW'(resp_s);
    kill_s        = kill_r - CW'(drop_s);
    if (jump_flag_i) begin
      pc_s          = {jump_addr_i[31:2], 2'b00};
      kill_s        = kill_r - CW'(drop_s) + outstanding_r - CW'(resp_s);
      outstanding_s = {CW{1'b0}};
    end else if (grant_s) begin
      pc_s = pc_step(pc_r);
    end else begin
      pc_s = pc_r;
    end
    if (kill_s != {CW{1'b0}}) begin
      state_s = FETCH_ST_FLUSH;
    end else begin
      state_s = FETCH_ST_FETCH;
    end
  end

  // IF/ID delivery straight from the instruction FIFO head.
  always_comb begin
    req_o  = req_s;
    addr_o = pc_r;
    if (rst || jump_flag_i || iq_empty_s) begin
      inst_o      = INST_NOP;
      inst_addr_o = ZERO_WORD;
      int_flag_o  = INT_NONE;
    end else begin
      inst_o      = iq_head_s.inst;
      inst_addr_o = iq_head_s.addr;
      int_flag_o  = int_flag_i;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_ADDR;
      outstanding_r <= {CW{1'b0}};
      kill_r        <= {CW{1'b0}};
      state_r       <= FETCH_ST_FETCH;
      req_pend_r    <= 1'b0;
    end else begin
      pc_r          <= pc_s;
      outstanding_r <= outstanding_s;
      kill_r        <= kill_s;
      state_r       <= state_s;
      req_pend_r    <= req_s && !gnt_i;
    end
  end

  fetch_fifo #(.DW(32), .DEPTH(FIFO_DEPTH)) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_s),
    .pop   (resp_s),
    .flush (jump_flag_i),
    .din   (pc_r),
    .head  (aq_head_s),
    .count (aq_count_s),
    .full  (aq_full_s),
    .empty (aq_empty_s)
  );

  fetch_fifo #(.DW(64), .DEPTH(FIFO_DEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (resp_s && !jump_flag_i),
    .pop   (iq_pop_s),
    .flush (jump_flag_i),
    .din   (iq_din_s),
    .head  (iq_head_s),
    .count (iq_count_s),
    .full  (iq_full_s),
    .empty (iq_empty_s)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed table, corner sequences, random traffic vs queue model.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [2:0]  hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [7:0]  int_flag_i;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [7:0]  int_flag_o;

  int checks   = 0;
  int failures = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .int_flag_i(int_flag_i), .req_o(req_o), .addr_o(addr_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .int_flag_o(int_flag_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Behavioural model: PC, in-flight requests {live, addr} and buffered instruction addresses.
  logic [32:0] inflight[$];
  logic [31:0] ibuf[$];
  logic [31:0] m_pc;
  bit          m_pend;
  bit          m_known = 1'b0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic bit m_flushing();
    foreach (inflight[i]) if (!inflight[i][32]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_req();
    if (rst || jump_flag_i || m_flushing()) return 1'b0;
    return m_pend || (hold_flag_i < 3'd1 && (inflight.size() + ibuf.size()) < 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("req", {31'd0, req_o}, {31'd0, m_req()});
    if (m_known) chk("addr", addr_o, m_pc);
    if (rst || jump_flag_i || ibuf.size() == 0) begin
      chk("inst", inst_o, 32'h0000_0013);
      chk("iaddr", inst_addr_o, 32'h0);
      chk("intf", {24'd0, int_flag_o}, 32'h0);
    end else begin
      chk("inst", inst_o, rom(ibuf[0]));
      chk("iaddr", inst_addr_o, ibuf[0]);
      chk("intf", {24'd0, int_flag_o}, {24'd0, int_flag_i});
    end
  endtask

  task automatic m_update();
    bit req, pop;
    logic [32:0] e;
    if (rst) begin
      inflight.delete(); ibuf.delete();
      m_pc = 32'h0; m_pend = 1'b0; m_known = 1'b1;
      return;
    end
    req = m_req();
    pop = !jump_flag_i && ibuf.size() > 0 && hold_flag_i < 3'd2;
    if (pop) void'(ibuf.pop_front());
    if (rvalid_i && inflight.size() > 0) begin
      e = inflight.pop_front();
      if (e[32] && !jump_flag_i) ibuf.push_back(e[31:0]);
    end
    if (req && gnt_i) begin
      inflight.push_back({1'b1, m_pc});
      m_pc = m_pc + 32'd4;
    end
    m_pend = req && !gnt_i;
    if (jump_flag_i) begin
      ibuf.delete();
      foreach (inflight[i]) inflight[i][32] = 1'b0;
      m_pc = {jump_addr_i[31:2], 2'b00};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  // rv: 0 none, 1 respond if something is in flight, 2 force a stray response
  task automatic drv(input logic [2:0] h, input bit j, input logic [31:0] ja,
                     input bit g, input int rv, input bit r);
    rst = r; hold_flag_i = h; jump_flag_i = j; jump_addr_i = ja; gnt_i = g;
    rvalid_i = (rv == 2) || (rv == 1 && inflight.size() > 0);
    rdata_i  = (rvalid_i && inflight.size() > 0) ? rom(inflight[0][31:0]) : $urandom;
    int_flag_i = 8'($urandom);
    #1;
    cmp_model();
    tick();
  endtask

  task automatic do_reset();
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b1);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b1);
  endtask

  typedef struct {
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic [7:0]  intf;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h000, 32'h0000_0013, 32'h000, 8'h00};
    tbl[1]  = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'h004, 32'h0000_0013, 32'h000, 8'h00};
    tbl[2]  = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5_A5A1, 1'b0, 32'h008, 32'hA5A5_A5A5, 32'h000, 8'h3C};
    tbl[3]  = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h008, 32'hA5A5_A5A1, 32'h004, 8'h3C};
    tbl[4]  = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hA5A5_A5AD, 1'b1, 32'h00C, 32'h0000_0013, 32'h000, 8'h00};
    tbl[5]  = '{3'd0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA5A5_A5A9, 1'b0, 32'h010, 32'hA5A5_A5AD, 32'h008, 8'h3C};
    tbl[6]  = '{3'd2, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h010, 32'hA5A5_A5A9, 32'h00C, 8'h3C};
    tbl[7]  = '{3'd2, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 32'h010, 32'hA5A5_A5A9, 32'h00C, 8'h3C};
    tbl[8]  = '{3'd0, 1'b1, 32'h103, 1'b1, 1'b0, 32'h0,         1'b0, 32'h010, 32'h0000_0013, 32'h000, 8'h00};
    tbl[9]  = '{3'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h100, 32'h0000_0013, 32'h000, 8'h00};
    tbl[10] = '{3'd0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b1, 32'h100, 32'h0000_0013, 32'h000, 8'h00};
    tbl[11] = '{3'd0, 1'b0, 32'h0,   1'b0, 1'b1, 32'hA5A5_A4A5, 1'b1, 32'h104, 32'h0000_0013, 32'h000, 8'h00};
    tbl[12] = '{3'd0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b1, 32'h104, 32'hA5A5_A4A5, 32'h100, 8'h3C};

    rst = 1'b1; hold_flag_i = 3'd0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
    int_flag_i = 8'h0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
    do_reset();

    // Directed table from reset
    for (int i = 0; i < 13; i++) begin
      rst = 1'b0; hold_flag_i = tbl[i].hold; jump_flag_i = tbl[i].jump; jump_addr_i = tbl[i].jaddr;
      gnt_i = tbl[i].gnt; rvalid_i = tbl[i].rvalid; rdata_i = tbl[i].rdata; int_flag_i = 8'h3C;
      #1;
      chk($sformatf("tbl%0d_req", i), {31'd0, req_o}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].inst);
      chk($sformatf("tbl%0d_iaddr", i), inst_addr_o, tbl[i].iaddr);
      chk($sformatf("tbl%0d_intf", i), {24'd0, int_flag_o}, {24'd0, tbl[i].intf});
      tick();
    end

    // Grant withheld for five cycles, then one grant advances PC by exactly 4
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(i[0] ? 3'd3 : 3'd0, 1'b0, 32'h0, 1'b0, 0, 1'b0);
      #1 chk("nognt_addr", addr_o, 32'h0);
      chk("nognt_req", {31'd0, req_o}, 32'd1);
    end
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    #1 chk("gnt_adv", addr_o, 32'h4);

    // PC wrap at the top of the address space
    do_reset();
    drv(3'd0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    #1 chk("wrap", addr_o, 32'h0);

    // Jump with two requests in flight: both responses are dropped
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b1, 32'h103, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    #1 chk("jmp_addr", addr_o, 32'h100);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    #1 chk("jmp_first", inst_addr_o, 32'h100);

    // Jump coincident with a response and a pending pop: one kill remains
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b1, 32'h200, 1'b1, 1, 1'b0);
    #1 chk("kill_req", {31'd0, req_o}, 32'd0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 0, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    #1 chk("kill_done", {31'd0, req_o}, 32'd1);
    chk("kill_inst", inst_o, 32'h0000_0013);

    // Reset mid-burst, then a stray response right after reset
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b1);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 2, 1'b0);
    drv(3'd0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int hs;
      logic [2:0] h;
      hs = $urandom_range(0, 9);
      h  = (hs < 7) ? 3'd0 : 3'(hs - 6);
      drv(h, $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
